// File: rtl/timer_share_arbiter.sv
// timer_share_arbiter: round-robin owner selection for one shared down-counter.
// The winner's delay is loaded and counted out. The owner then gets a one-cycle done pulse.
// Ports:
//   clk_FPGA   - system clock, rising edge
//   reset      - asynchronous, active-low reset
//   req        - per-requester level request, held until done or dropped (abort)
//   load_value - per-requester delay, slice i = [i*CNT_WIDTH +: CNT_WIDTH]
//   grant      - registered one-hot (or zero) current timer owner
//   done       - registered one-cycle expiry pulse to the owner
//   busy       - registered, high whenever the sequencer is not idle
//   count      - registered remaining count
module timer_share_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                      clk_FPGA,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*CNT_WIDTH-1:0] load_value,
  output logic [NREQ-1:0]           grant,
  output logic [NREQ-1:0]           done,
  output logic                      busy,
  output logic [CNT_WIDTH-1:0]      count
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;

  logic [1:0]           r_state,  w_state_nxt;
  logic [NREQ-1:0]      r_grant,  w_grant_nxt;
  logic [NREQ-1:0]      r_done,   w_done_nxt;
  logic                 r_busy,   w_busy_nxt;
  logic [CNT_WIDTH-1:0] r_count,  w_count_nxt;
  logic [PTR_W-1:0]     r_ptr,    w_ptr_nxt;
  logic [PTR_W-1:0]     r_owner,  w_owner_nxt;

  logic                 w_sel_valid;
  logic [PTR_W-1:0]     w_sel_idx;
  logic [NREQ-1:0]      w_sel_onehot;
  logic [CNT_WIDTH-1:0] w_own_load;
  logic                 w_own_req;
  logic [PTR_W-1:0]     w_ptr_after_owner;
  logic                 w_release;
  logic                 w_expire;

  // (base + ofs) mod NREQ, with ofs < NREQ
  function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] base,
                                                input int unsigned ofs);
    int unsigned s;
    s = 32'(base) + ofs;
    if (s >= NREQ) s = s - NREQ;
    return PTR_W'(s);
  endfunction

  // First set request scanning from the round-robin pointer
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!w_sel_valid && req[rr_index(r_ptr, k)]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = rr_index(r_ptr, k);
      end
    end
  end

  // One-hot form of the selected index
  always_comb begin
    w_sel_onehot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_sel_onehot[i] = (w_sel_idx == PTR_W'(i));
    end
  end

  // Owner's delay value and request level
  always_comb begin
    w_own_load = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (r_owner == PTR_W'(i)) w_own_load = load_value[i*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  assign w_own_req         = |(req & r_grant);
  assign w_ptr_after_owner = (r_owner == PTR_W'(NREQ - 1)) ? '0 : r_owner + PTR_W'(1);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    w_count_nxt = r_count;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_busy_nxt  = 1'b0;
    w_release   = 1'b0;
    w_expire    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) begin
          w_state_nxt = S_LOAD;
          w_grant_nxt = w_sel_onehot;
          w_owner_nxt = w_sel_idx;
        end
      end
      S_LOAD: begin
        if (!w_own_req) begin
          w_release = 1'b1;
        end else if (w_own_load == '0) begin
          w_release = 1'b1;
          w_expire  = 1'b1;
        end else begin
          w_count_nxt = w_own_load;
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!w_own_req) begin
          w_release = 1'b1;
        end else if (r_count == CNT_WIDTH'(1)) begin
          w_release = 1'b1;
          w_expire  = 1'b1;
        end else begin
          w_count_nxt = r_count - CNT_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
        w_count_nxt = '0;
      end
    endcase

    // Finish and abort share the release path; only finish pulses done
    if (w_release) begin
      w_state_nxt = S_IDLE;
      w_grant_nxt = '0;
      w_count_nxt = '0;
      w_ptr_nxt   = w_ptr_after_owner;
      w_done_nxt  = w_expire ? r_grant : '0;
    end

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk_FPGA or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_count <= '0;
      r_ptr   <= '0;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;
  assign count = r_count;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Directed bench for timer_share_arbiter (NREQ=4, CNT_WIDTH=16).
module tb_timer_share_arbiter;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned CNT_WIDTH = 16;

  logic                      clk_FPGA = 1'b0;
  logic                      reset;
  logic [NREQ-1:0]           req;
  logic [NREQ*CNT_WIDTH-1:0] load_value;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           done;
  logic                      busy;
  logic [CNT_WIDTH-1:0]      count;

  int n_checks = 0;
  int n_fail   = 0;

  timer_share_arbiter #(.NREQ(NREQ), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_FPGA   (clk_FPGA),
    .reset      (reset),
    .req        (req),
    .load_value (load_value),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .count      (count)
  );

  always #5 clk_FPGA = ~clk_FPGA;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_FPGA);
    #1;
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b0;
    #20;
    reset = 1'b1;
    tick();
  endtask

  // Ticks until done is seen or the bound runs out; returns ticks taken
  task automatic wait_done(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done == '0 && cyc < max_cyc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;

    req        = '0;
    load_value = '0;
    reset      = 1'b0;
    #20;
    check_eq("rst_grant", 32'(grant), 32'h0);
    check_eq("rst_done",  32'(done),  32'h0);
    check_eq("rst_count", 32'(count), 32'h0);
    check_eq("rst_busy",  32'(busy),  32'h0);
    reset = 1'b1;
    tick();

    // Single request, delay 5
    load_value[0*CNT_WIDTH +: CNT_WIDTH] = 16'd5;
    req = 4'b0001;
    tick();
    check_eq("t1_grant", 32'(grant), 32'h1);
    check_eq("t1_busy",  32'(busy),  32'h1);
    for (int v = 5; v >= 1; v--) begin
      tick();
      check_eq("t1_count", 32'(count), 32'(v));
      check_eq("t1_nodone", 32'(done), 32'h0);
    end
    tick();
    check_eq("t1_done",   32'(done),  32'h1);
    check_eq("t1_grant0", 32'(grant), 32'h0);
    check_eq("t1_busy0",  32'(busy),  32'h0);
    req = '0;
    tick();
    check_eq("t1_done_pulse", 32'(done), 32'h0);
    check_eq("t1_idle",       32'(busy), 32'h0);

    // All four requesting, delay 2 each: round-robin rotation
    do_reset();
    for (int i = 0; i < 4; i++) load_value[i*CNT_WIDTH +: CNT_WIDTH] = 16'd2;
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      check_eq("t2_grant", 32'(grant), 32'(exp_g[n]));
      wait_done(10, cyc);
      check_eq("t2_delay", 32'(cyc), 32'd3);
      check_eq("t2_done",  32'(done), 32'(exp_g[n]));
      check_eq("t2_grant_off", 32'(grant), 32'h0);
      if (n < 4) tick();
    end
    req = '0;
    tick();

    // Zero delay finishes one cycle after grant
    do_reset();
    load_value[2*CNT_WIDTH +: CNT_WIDTH] = 16'd0;
    req = 4'b0100;
    tick();
    check_eq("t3_grant", 32'(grant), 32'h4);
    wait_done(5, cyc);
    check_eq("t3_delay", 32'(cyc), 32'd1);
    check_eq("t3_done",  32'(done), 32'h4);
    check_eq("t3_count", 32'(count), 32'h0);
    req = '0;
    tick();

    // Abort at count 3; pointer moves past the aborted owner
    do_reset();
    load_value[1*CNT_WIDTH +: CNT_WIDTH] = 16'd5;
    load_value[0*CNT_WIDTH +: CNT_WIDTH] = 16'd4;
    load_value[2*CNT_WIDTH +: CNT_WIDTH] = 16'd4;
    load_value[3*CNT_WIDTH +: CNT_WIDTH] = 16'd4;
    req = 4'b0010;
    tick();
    check_eq("t4_grant", 32'(grant), 32'h2);
    tick(); tick(); tick();
    check_eq("t4_count3", 32'(count), 32'd3);
    req = 4'b1101;
    tick();
    check_eq("t4_abort_grant", 32'(grant), 32'h0);
    check_eq("t4_abort_done",  32'(done),  32'h0);
    check_eq("t4_abort_count", 32'(count), 32'h0);
    tick();
    check_eq("t4_next_grant", 32'(grant), 32'h4);
    req = '0;
    tick();
    check_eq("t4_load_abort", 32'(grant), 32'h0);
    check_eq("t4_load_abort_done", 32'(done), 32'h0);

    // Asynchronous reset at count 7
    do_reset();
    load_value[3*CNT_WIDTH +: CNT_WIDTH] = 16'd10;
    req = 4'b1000;
    tick();
    check_eq("t5_grant", 32'(grant), 32'h8);
    tick(); tick(); tick(); tick();
    check_eq("t5_count7", 32'(count), 32'd7);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_ar_grant", 32'(grant), 32'h0);
    check_eq("t5_ar_done",  32'(done),  32'h0);
    check_eq("t5_ar_count", 32'(count), 32'h0);
    check_eq("t5_ar_busy",  32'(busy),  32'h0);
    req = 4'b1010;
    load_value[1*CNT_WIDTH +: CNT_WIDTH] = 16'd1;
    #15;
    reset = 1'b1;
    tick();
    check_eq("t5_post_grant", 32'(grant), 32'h2);
    wait_done(5, cyc);
    check_eq("t5_post_delay", 32'(cyc), 32'd2);
    check_eq("t5_post_done",  32'(done), 32'h2);
    req = '0;
    tick();

    // Maximum delay
    do_reset();
    load_value[0*CNT_WIDTH +: CNT_WIDTH] = 16'hFFFF;
    req = 4'b0001;
    tick();
    check_eq("t6_grant", 32'(grant), 32'h1);
    tick();
    check_eq("t6_load", 32'(count), 32'hFFFF);
    wait_done(70000, cyc);
    check_eq("t6_delay", 32'(cyc + 1), 32'd65536);
    check_eq("t6_done",  32'(done), 32'h1);
    check_eq("t6_count", 32'(count), 32'h0);
    req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
